// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl
// Bit-serial sequencer for one external 1-bit full-adder slice. Operands are
// captured on an accepted start, fed LSB first through the shared adder cell
// one bit per clock, and the WIDTH-bit sum plus final carry are registered
// when the last bit returns.
//
// Build option: define SERIAL_ADD_SUB_EN to add the 'sub' input. With sub=1
// the cell computes a + ~b + 1, i.e. a - b, and Cout=1 means no borrow.
module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             Cin,
`ifdef SERIAL_ADD_SUB_EN
    input  logic             sub,
`endif
    output logic             fa_a,
    output logic             fa_b,
    output logic             fa_cin,
    input  logic             fa_sum,
    input  logic             fa_cout,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout
);

    localparam int              CW     = $clog2(WIDTH);
    localparam logic [CW-1:0]   LAST   = CW'(WIDTH - 1);

    localparam logic [1:0]      S_IDLE = 2'd0;
    localparam logic [1:0]      S_RUN  = 2'd1;
    localparam logic [1:0]      S_DONE = 2'd2;

    logic [1:0]       r_state;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_a_sr;
    logic [WIDTH-1:0] r_b_sr;
    // Holds only the upper WIDTH-1 partial-sum bits: the lowest bit of a full
    // WIDTH-wide shift register would be shifted out before it is ever used.
    logic [WIDTH-2:0] r_s_sr;
    logic             r_carry;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;

    logic             w_in_run;
    logic             w_accept;
    logic             w_last;
    logic [WIDTH-1:0] w_b_load;
    logic             w_c_load;
    logic [WIDTH-1:0] w_s_next;

    assign w_in_run = (r_state == S_RUN);
    assign w_accept = (r_state == S_IDLE) && start;
    assign w_last   = w_in_run && (r_cnt == LAST);

    // New partial sum once the returning bit is shifted in from the top.
    assign w_s_next = {fa_sum, r_s_sr};

    // Operand B and initial carry as loaded on an accepted start.
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path
        // through the block leaves it unassigned and no latch is inferred.
        w_b_load = b;
        w_c_load = Cin;
`ifdef SERIAL_ADD_SUB_EN
        if (sub) begin
            w_b_load = ~b;
            w_c_load = 1'b1;
        end
`endif
    end

    // Sequencing FSM: IDLE -> RUN on start, RUN -> DONE after the last bit,
    // DONE -> IDLE unconditionally one cycle later.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // register samples pre-edge values regardless of statement order.
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:  if (start)  r_state <= S_RUN;
                S_RUN:   if (w_last) r_state <= S_DONE;
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Bit counter: cleared on accept, advanced each RUN edge, cleared again
    // on the last bit so it never exceeds WIDTH-1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (w_accept || w_last) begin
            r_cnt <= '0;
        end else if (w_in_run) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Operand shift registers and carry flip-flop feeding the adder cell.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a_sr  <= '0;
            r_b_sr  <= '0;
            r_carry <= 1'b0;
        end else if (w_accept) begin
            r_a_sr  <= a;
            r_b_sr  <= w_b_load;
            r_carry <= w_c_load;
        end else if (w_in_run) begin
            r_a_sr  <= {1'b0, r_a_sr[WIDTH-1:1]};
            r_b_sr  <= {1'b0, r_b_sr[WIDTH-1:1]};
            r_carry <= fa_cout;
        end
    end

    // Partial-sum shift register collecting adder sum bits LSB first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s_sr <= '0;
        end else if (w_in_run) begin
            r_s_sr <= w_s_next[WIDTH-1:1];
        end
    end

    // Result registers: updated only on the last bit, held otherwise so the
    // previous result stays readable through the next operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sum  <= '0;
            r_cout <= 1'b0;
        end else if (w_last) begin
            r_sum  <= w_s_next;
            r_cout <= fa_cout;
        end
    end

    // Adder-cell drive is gated to RUN so the cell sees zeros when idle.
    assign fa_a   = w_in_run & r_a_sr[0];
    assign fa_b   = w_in_run & r_b_sr[0];
    assign fa_cin = w_in_run & r_carry;

    assign busy   = w_in_run;
    assign done   = (r_state == S_DONE);
    assign Sum    = r_sum;
    assign Cout   = r_cout;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb_serial_add_ctrl
// Drives serial_add_ctrl (WIDTH=8) with directed and random operations. The
// external full-adder cell is modelled behaviourally; expected results and
// per-bit carries come from plain integer arithmetic on the operands.
// Define SERIAL_ADD_SUB_EN to exercise subtraction as well.
module tb_serial_add_ctrl;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         Cin;
    logic         sub_i;
    logic         fa_a;
    logic         fa_b;
    logic         fa_cin;
    logic         fa_sum;
    logic         fa_cout;
    logic         busy;
    logic         done;
    logic [W-1:0] Sum;
    logic         Cout;

    int n_vec  = 0;
    int n_miss = 0;

    // Previously completed result; the DUT must hold it during the next op.
    logic [W:0] held;

    serial_add_ctrl #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .a       (a),
        .b       (b),
        .Cin     (Cin),
`ifdef SERIAL_ADD_SUB_EN
        .sub     (sub_i),
`endif
        .fa_a    (fa_a),
        .fa_b    (fa_b),
        .fa_cin  (fa_cin),
        .fa_sum  (fa_sum),
        .fa_cout (fa_cout),
        .busy    (busy),
        .done    (done),
        .Sum     (Sum),
        .Cout    (Cout)
    );

    // The shared full-adder cell.
    assign {fa_cout, fa_sum} = 2'(fa_a) + 2'(fa_b) + 2'(fa_cin);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_quiet(input string tag);
        check({tag, " busy"}, 32'(busy), 32'd0);
        check({tag, " done"}, 32'(done), 32'd0);
        check({tag, " fa"}, {29'd0, fa_a, fa_b, fa_cin}, 32'd0);
    endtask

    // One full operation. Entered #1 after an edge with the DUT in IDLE and
    // leaves #1 after the edge that returns it to IDLE, so calls chain
    // back-to-back. With noise set, operands and start are scrambled while
    // the operation runs and during DONE.
    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                          input logic tc, input logic ts, input bit noise);
        int         eff_b;
        int         eff_c;
        int         full;
        int         lo;
        logic [W:0] exp_res;
        eff_b   = ts ? int'(~tb_v) : int'(tb_v);
        eff_c   = ts ? 1 : int'(tc);
        full    = int'(ta) + eff_b + eff_c;
        exp_res = full[W:0];

        check_quiet("idle");
        start = 1'b1; a = ta; b = tb_v; Cin = tc; sub_i = ts;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < W; i++) begin
            lo = (int'(ta) % (1 << i)) + (eff_b % (1 << i)) + eff_c;
            check($sformatf("run%0d busy", i), 32'(busy), 32'd1);
            check($sformatf("run%0d done", i), 32'(done), 32'd0);
            check($sformatf("run%0d fa_a", i), 32'(fa_a), 32'(ta[i]));
            check($sformatf("run%0d fa_b", i), 32'(fa_b), 32'((eff_b >> i) & 1));
            check($sformatf("run%0d fa_cin", i), 32'(fa_cin), 32'((lo >> i) & 1));
            check($sformatf("run%0d held", i), {23'd0, Cout, Sum}, 32'(held));
            if (noise) begin
                a = W'($urandom); b = W'($urandom); Cin = 1'($urandom);
                sub_i = 1'($urandom); start = 1'($urandom);
            end
            @(posedge clk); #1;
        end
        check("done pulse", 32'(done), 32'd1);
        check("done busy", 32'(busy), 32'd0);
        check("done fa", {29'd0, fa_a, fa_b, fa_cin}, 32'd0);
        check("result", {23'd0, Cout, Sum}, 32'(exp_res));
        held = exp_res;
        start = 1'b0;
        @(posedge clk); #1;
        check_quiet("after");
        check("after held", {23'd0, Cout, Sum}, 32'(held));
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; a = '0; b = '0; Cin = 1'b0; sub_i = 1'b0;
        held  = '0;
        #12;
        check_quiet("reset");
        check("reset result", {23'd0, Cout, Sum}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Directed operations; the second pair runs back-to-back.
        run_op(8'h5A, 8'h33, 1'b0, 1'b0, 1'b0);
        run_op(8'hFF, 8'h01, 1'b0, 1'b0, 1'b0);
        run_op(8'hFF, 8'h00, 1'b1, 1'b0, 1'b0);
        // Restart requests and operand churn during RUN/DONE must be ignored.
        run_op(8'h0F, 8'h01, 1'b0, 1'b0, 1'b1);

        // Asynchronous reset in the middle of an operation.
        start = 1'b1; a = 8'h12; b = 8'h34; Cin = 1'b0; sub_i = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        check("pre-reset busy", 32'(busy), 32'd1);
        #3 rst_n = 1'b0;
        #1;
        check_quiet("mid reset");
        check("mid reset result", {23'd0, Cout, Sum}, 32'd0);
        held = '0;
        @(posedge clk); #1;
        check_quiet("in reset");
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_op(8'h01, 8'h01, 1'b0, 1'b0, 1'b0);

`ifdef SERIAL_ADD_SUB_EN
        run_op(8'h10, 8'h01, 1'b0, 1'b1, 1'b0);
        run_op(8'h00, 8'h01, 1'b1, 1'b1, 1'b0);
        run_op(8'h10, 8'h01, 1'b1, 1'b0, 1'b0);
`endif

        // Random operations, some with interference, including edge operands.
        for (int k = 0; k < 40; k++) begin
            logic [W-1:0] ra;
            logic [W-1:0] rb;
            logic         rs;
            ra = W'($urandom);
            rb = W'($urandom);
            if (k % 10 == 0) ra = '1;
            if (k % 10 == 1) rb = '1;
`ifdef SERIAL_ADD_SUB_EN
            rs = 1'($urandom);
`else
            rs = 1'b0;
`endif
            run_op(ra, rb, 1'($urandom), rs, 1'($urandom));
            if ($urandom_range(0, 2) == 0) begin
                @(posedge clk); #1;
                check_quiet("gap");
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
